// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole hole controller.
// State encoding, LFSR constants and width helpers.
package mole_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_RAISE,
    S_UP,
    S_LOWER,
    S_GAP
  } state_t;

  localparam int          LFSR_W    = 16;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR, free running from reset.
// Only the low OUT_W bits are exported to the hole picker.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] bits
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset)
      lfsr <= SEED;
    else
      lfsr <= {1'b0, lfsr[LFSR_W-1:1]}
            ^ (lfsr[0] ? LFSR_TAPS : '0);
  end

  assign bits = lfsr[OUT_W-1:0];

endmodule

// File: rtl/mole_toggle_ctrl.sv
// Mole sequencer: picks a hole, pulses its toggle flop up and down,
// and reports hit / miss / wrong-button events to the score logic.
module mole_toggle_ctrl
  import mole_pkg::*;
#(
  parameter int          N_HOLES   = 4,
  parameter int          UP_TICKS  = 8,
  parameter int          GAP_TICKS = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        tick,
  input  logic [N_HOLES-1:0]          hit_btn,
  input  logic [N_HOLES-1:0]          mole_q,
  output logic [N_HOLES-1:0]          toggle,
  output logic [clog2(N_HOLES)-1:0]   hole_idx,
  output logic                        hit_pulse,
  output logic                        miss_pulse,
  output logic                        wrong_pulse,
  output logic                        busy
);

  localparam int IW = clog2(N_HOLES);
  localparam int CW = clog2(max2(UP_TICKS, GAP_TICKS) + 1);

  state_t          state, nxt;
  logic [IW-1:0]   rnd, cand;
  logic [CW-1:0]   up_cnt, gap_cnt;
  logic [N_HOLES-1:0] sel;
  logic            is_up, hit_c, wrong_c, time_out, gap_done;
  logic            hit_n, miss_n, wrong_n;

  mole_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (IW)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .bits  (rnd)
  );

  // hole_idx doubles as prev_idx, so a repeat bumps to the next hole
  always_comb begin
    cand = rnd;
    if (cand == hole_idx) cand = cand + IW'(1);
  end

  assign sel      = N_HOLES'(1) << hole_idx;
  assign is_up    = mole_q[hole_idx];
  assign hit_c    = hit_btn[hole_idx];
  assign wrong_c  = |(hit_btn & ~sel);
  assign time_out = tick && (up_cnt == CW'(UP_TICKS - 1));
  assign gap_done = tick && (gap_cnt == CW'(GAP_TICKS - 1));
  assign busy     = (state != S_IDLE);

  always_comb begin
    nxt     = state;
    toggle  = '0;
    hit_n   = 1'b0;
    miss_n  = 1'b0;
    wrong_n = 1'b0;
    unique case (state)
      S_IDLE:  if (enable) nxt = S_PICK;
      S_PICK:  nxt = enable ? S_RAISE : S_IDLE;
      // raise is withheld when aborting so LOWER cannot follow back-to-back
      S_RAISE: begin
        if (!enable) nxt = S_LOWER;
        else begin
          nxt = S_UP;
          if (!is_up) toggle = sel;
        end
      end
      S_UP: begin
        if (!enable) nxt = S_LOWER;
        else begin
          wrong_n = wrong_c;
          if (hit_c) begin
            hit_n = 1'b1;
            nxt   = S_LOWER;
          end else if (time_out) begin
            miss_n = 1'b1;
            nxt    = S_LOWER;
          end
        end
      end
      S_LOWER: begin
        nxt = S_GAP;
        if (is_up) toggle = sel;
      end
      S_GAP:   if (gap_done) nxt = enable ? S_PICK : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      hole_idx    <= '0;
      up_cnt      <= '0;
      gap_cnt     <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      wrong_pulse <= 1'b0;
    end else begin
      state       <= nxt;
      hit_pulse   <= hit_n;
      miss_pulse  <= miss_n;
      wrong_pulse <= wrong_n;
      if (state == S_PICK && enable) hole_idx <= cand;
      if (state == S_RAISE)
        up_cnt <= '0;
      else if (state == S_UP && tick)
        up_cnt <= up_cnt + CW'(1);
      if (state == S_LOWER)
        gap_cnt <= '0;
      else if (state == S_GAP && tick)
        gap_cnt <= gap_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mole_toggle_ctrl.sv
// Directed bench for mole_toggle_ctrl with modelled hole flops.
// N_HOLES=4, UP_TICKS=3, GAP_TICKS=2, tick held high.
module tb_mole_toggle_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, tick;
  logic [3:0] hit_btn;
  logic [3:0] mole_q;
  logic [3:0] toggle;
  logic [1:0] hole_idx;
  logic       hit_pulse, miss_pulse, wrong_pulse, busy;

  int total = 0;
  int bad   = 0;
  int hist [4] = '{0, 0, 0, 0};

  logic [15:0] m_lfsr;
  logic [1:0]  exp_h, exp_prev, last_idx;
  logic [3:0]  prev_tog = 4'b0;
  bit          mon = 1'b0;

  always #5 clk = ~clk;

  mole_toggle_ctrl #(
    .N_HOLES   (4),
    .UP_TICKS  (3),
    .GAP_TICKS (2),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .hit_btn     (hit_btn),
    .mole_q      (mole_q),
    .toggle      (toggle),
    .hole_idx    (hole_idx),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .wrong_pulse (wrong_pulse),
    .busy        (busy)
  );

  function automatic logic [15:0] nlfsr(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [1:0] pick(input logic [1:0] c,
                                      input logic [1:0] p);
    return (c == p) ? c + 2'd1 : c;
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // hole toggle flops and reference LFSR
  always @(posedge clk) begin
    if (!reset) begin
      mole_q <= 4'b0;
      m_lfsr <= 16'hACE1;
    end else begin
      mole_q <= mole_q ^ toggle;
      m_lfsr <= nlfsr(m_lfsr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tk;
    @(posedge clk);
    #1;
  endtask

  // called while the DUT sits in PICK
  task automatic do_pick;
    exp_h    = pick(m_lfsr[1:0], exp_prev);
    exp_prev = exp_h;
  endtask

  always @(negedge clk) begin
    if (mon) begin
      chk("onehot", 32'($countones(toggle) <= 1), 1);
      if (prev_tog != 4'b0) chk("consec", toggle, 0);
      prev_tog = toggle;
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b1; tick = 1'b1; hit_btn = 4'b0;
    exp_prev = 2'd0; exp_h = 2'd0;
    // 1: reset and first raise
    tk;
    chk("rst_tog", toggle, 0);
    chk("rst_busy", busy, 0);
    mon = 1'b1;
    tk;
    chk("rst_idx", hole_idx, 0);
    chk("rst_pulses", {hit_pulse, miss_pulse, wrong_pulse}, 0);
    reset = 1'b1;
    tk;
    chk("pick_busy", busy, 1);
    chk("pick_tog", toggle, 0);
    do_pick;
    tk;
    chk("t1_tog", toggle, oh(exp_h));
    chk("t1_idx_hand", hole_idx, 2'd1);
    chk("t1_idx", hole_idx, exp_h);
    tk;
    chk("t1_up", mole_q, oh(exp_h));
    chk("t1_tog_off", toggle, 0);
    // 2: timeout
    tk; chk("t2_nomiss1", miss_pulse, 0);
    tk; chk("t2_nomiss2", miss_pulse, 0);
    tk;
    chk("t2_miss", miss_pulse, 1);
    chk("t2_lower", toggle, oh(exp_h));
    tk;
    chk("t2_miss_once", miss_pulse, 0);
    chk("t2_down", mole_q, 0);
    chk("t2_gap_busy", busy, 1);
    tk;
    tk; do_pick;
    tk;
    chk("t3_raise", toggle, oh(exp_h));
    // 3: hit in second UP cycle
    tk;
    tk; hit_btn = oh(exp_h);
    tk; hit_btn = 4'b0;
    chk("t3_hit", hit_pulse, 1);
    chk("t3_lower", toggle, oh(exp_h));
    chk("t3_nomiss", miss_pulse, 0);
    tk;
    chk("t3_hit_once", hit_pulse, 0);
    chk("t3_down", mole_q, 0);
    tk;
    chk("t3_nomiss2", miss_pulse, 0);
    tk; do_pick;
    tk;
    chk("t4_raise", toggle, oh(exp_h));
    // 4: wrong button, then hit coinciding with timeout
    tk; hit_btn = oh(exp_h + 2'd1);
    tk; hit_btn = 4'b0;
    chk("t4_wrong", wrong_pulse, 1);
    chk("t4_nohit", hit_pulse, 0);
    chk("t4_stay", mole_q, oh(exp_h));
    chk("t4_notog", toggle, 0);
    tk;
    chk("t4_wrong_once", wrong_pulse, 0);
    hit_btn = oh(exp_h);
    tk; hit_btn = 4'b0;
    chk("t4_hitwins", hit_pulse, 1);
    chk("t4_nomiss", miss_pulse, 0);
    chk("t4_lower", toggle, oh(exp_h));
    tk;
    chk("t4_nomiss2", miss_pulse, 0);
    tk;
    tk; do_pick;
    tk;
    chk("t5_raise0", toggle, oh(exp_h));
    hist[hole_idx]++;
    // 5: 200 unattended moles
    for (int m = 0; m < 200; m++) begin
      last_idx = hole_idx;
      repeat (3) tk;
      tk;
      chk("t5_miss", miss_pulse, 1);
      chk("t5_lower", toggle, oh(exp_h));
      tk;
      tk;
      tk; do_pick;
      tk;
      chk("t5_raise", toggle, oh(exp_h));
      chk("t5_norepeat", 32'(hole_idx != last_idx), 1);
      hist[hole_idx]++;
    end
    for (int h = 0; h < 4; h++)
      chk("t5_hist", 32'(hist[h] >= 20), 1);
    // 6: enable drop during UP, then reset during UP
    tk; enable = 1'b0;
    tk;
    chk("t6_lower", toggle, oh(exp_h));
    chk("t6_nopulse", {hit_pulse, miss_pulse}, 0);
    chk("t6_busy_l", busy, 1);
    tk;
    chk("t6_down", mole_q, 0);
    tk;
    chk("t6_busy_g", busy, 1);
    tk;
    chk("t6_idle", busy, 0);
    enable = 1'b1;
    tk; do_pick;
    tk;
    chk("t6_raise", toggle, oh(exp_h));
    tk;
    chk("t6_up", mole_q, oh(exp_h));
    reset = 1'b0;
    tk;
    chk("t6_rst_tog", toggle, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_idx", hole_idx, 0);
    chk("t6_rst_q", mole_q, 0);
    exp_prev = 2'd0;
    reset = 1'b1; enable = 1'b0;
    tk; tk;
    chk("t6_stay_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
